// File: rtl/mvau_defn.sv
// rtl/mvau_defn.sv - shared constants, state type and width helper for the MVU PE accumulator
// Contents: default TDstI/SF/NF, counter widths SF_W/NF_W, state_t {S_ACC, S_HOLD},
//           cnt_w() giving a counter width of $clog2(n) with a floor of 1 bit.
package mvau_defn;

  localparam int TDstI = 16;
  localparam int SF    = 4;
  localparam int NF    = 2;

  // Counters never collapse to zero width, so SF=1 / NF=1 still build.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int SF_W = cnt_w(SF);
  localparam int NF_W = cnt_w(NF);

  typedef enum logic {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/mvu_pe_acc_cnt.sv
// rtl/mvu_pe_acc_cnt.sv - wrap counter: counts 0..max, returns to 0 after max
// Ports: clk (rising edge), clr (synchronous clear, wins over en), en (advance),
//        max (terminal value), cnt (current count), at_max (cnt == max).
module mvu_pe_acc_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  assign at_max = (cnt == max);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_max ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mvu_pe_acc_ctrl.sv
// rtl/mvu_pe_acc_ctrl.sv - per-PE accumulation sequencer: SF beats -> one neuron result
// Ports: aclk, areset (sync, active-high); in_v/in_rdy/in_add input beat stream;
//        out_v/out_rdy/out_acc/out_last result stream, out_last marks neuron fold NF-1.
// Build option: MVU_ACC_SAT_EN makes every add saturate instead of wrapping.
module mvu_pe_acc_ctrl
  import mvau_defn::state_t, mvau_defn::S_ACC, mvau_defn::S_HOLD, mvau_defn::cnt_w;
#(
  parameter int SF    = mvau_defn::SF,
  parameter int NF    = mvau_defn::NF,
  parameter int TDstI = mvau_defn::TDstI
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             in_v,
  output logic             in_rdy,
  input  logic [TDstI-1:0] in_add,
  output logic             out_v,
  input  logic             out_rdy,
  output logic [TDstI-1:0] out_acc,
  output logic             out_last
);

  localparam int SF_W = cnt_w(SF);
  localparam int NF_W = cnt_w(NF);
  localparam logic [SF_W-1:0] SF_MAX = SF_W'(SF - 1);
  localparam logic [NF_W-1:0] NF_MAX = NF_W'(NF - 1);

  state_t           state;
  logic [TDstI-1:0] acc;
  logic [TDstI-1:0] add_acc;
  logic [TDstI-1:0] sum;
  logic [SF_W-1:0]  sf_cnt;
  logic [NF_W-1:0]  nf_cnt;
  logic             sf_last;
  logic             nf_last;
  logic             beat;
  logic             out_hs;

  // In S_HOLD a new beat is only taken when the held result leaves in the
  // same cycle, which keeps back-to-back folds bubble-free.
  assign in_rdy = !areset && ((state == S_ACC) || out_rdy);
  assign beat   = in_v && in_rdy;
  assign out_hs = out_v && out_rdy;

  mvu_pe_acc_cnt #(.W(SF_W)) u_sf_cnt (
    .clk    (aclk),
    .clr    (areset),
    .en     (beat),
    .max    (SF_MAX),
    .cnt    (sf_cnt),
    .at_max (sf_last)
  );

  mvu_pe_acc_cnt #(.W(NF_W)) u_nf_cnt (
    .clk    (aclk),
    .clr    (areset),
    .en     (beat && sf_last),
    .max    (NF_MAX),
    .cnt    (nf_cnt),
    .at_max (nf_last)
  );

`ifdef MVU_ACC_SAT_EN
  // One guard bit: overflow when the two top bits disagree; the guard bit
  // then carries the true sign and selects the clamp value.
  logic [TDstI:0] wide;
  assign wide    = {acc[TDstI-1], acc} + {in_add[TDstI-1], in_add};
  assign add_acc = (wide[TDstI] != wide[TDstI-1])
                 ? {wide[TDstI], {(TDstI-1){~wide[TDstI]}}}
                 : wide[TDstI-1:0];
`else
  assign add_acc = acc + in_add;
`endif

  // First beat of a fold loads, so no explicit accumulator clear is needed.
  always_comb begin
    sum = add_acc;
    if (sf_cnt == '0) begin
      sum = in_add;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= S_ACC;
      acc      <= '0;
      out_acc  <= '0;
      out_v    <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (beat) begin
        acc <= sum;
      end
      if (beat && sf_last) begin
        out_acc  <= sum;
        out_last <= nf_last;
        out_v    <= 1'b1;
        state    <= S_HOLD;
      end else if (out_hs) begin
        out_v <= 1'b0;
        state <= S_ACC;
      end
    end
  end

endmodule
